bsg_zynq_fifo_packet_arbiter: RTL and testbench
===============================================

// Module: bsg_zynq_fifo_packet_arbiter
// PURPOSE
//  Shares one pl_to_ps FIFO port of a bsg_zynq_pl_shell among num_src_p ps_to_pl FIFO sources
//  (valid/yumi), e.g. the two shells of a dual-AXI-slave design, with round-robin fairness.
//  Traffic is packetised: a header word carries the payload length, and a grant is held until the
//  whole packet passes, so packets are never interleaved. The output is registered (1 entry).
// PARAMETERS
//  num_src_p     2   number of requesting sources (>=1)
//  data_width_p  32  FIFO word width (C_S_AXI_DATA_WIDTH)
//  len_width_p   8   header bits [len_width_p-1:0] = payload words following header (0..2^len-1)
// PORTS
//  clk_i        in   1                         clock
//  reset_i      in   1                         synchronous, active-high reset
//  src_data_i   in   num_src_p*data_width_p    per-source word (ps_to_pl_fifo_data_o)
//  src_v_i      in   num_src_p                 per-source valid (ps_to_pl_fifo_v_o)
//  src_yumi_o   out  num_src_p                 per-source dequeue (ps_to_pl_fifo_yumi_i), <=1 hot
//  data_o       out  data_width_p              output word (pl_to_ps_fifo_data_i)
//  v_o          out  1                         output valid (pl_to_ps_fifo_v_i)
//  ready_i      in   1                         sink ready (pl_to_ps_fifo_ready_o)
//  grant_o      out  num_src_p                 one-hot locked source; 0 when IDLE
//  busy_o       out  1                         1 when in BUSY (mid-packet)
//  src_id_o     out  safe_clog2(num_src_p)     source index of the word held in data_o
// BEHAVIOUR
//  - Reset: v_o=0, src_yumi_o=0, grant_o=0, busy_o=0, src_id_o=0, data_o=0, rr_ptr=0, cnt=0, IDLE.
//  - Output slot: take = ~v_o_r | ready_i. A word is accepted only when take=1; on accept,
//    src_yumi_o[g]=1 in that cycle (combinational from src_v_i, state, take) and data_o/src_id_o/v_o
//    load next edge. Latency source->data_o: 1 cycle. Full throughput: 1 word/cycle with ready_i=1.
//  - If take=1 and no word accepted, v_o clears next edge when ready_i=1. data_o held stable while
//    v_o=1 & ready_i=0.
//  - IDLE: grant g = first valid source scanning rr_ptr, rr_ptr+1, ... (mod num_src_p). On header
//    accept: len==0 -> stay IDLE, rr_ptr=g+1 mod N; len>0 -> BUSY, grant_r=g, cnt=len.
//    No valid source or take=0 -> no yumi, no state change.
//  - BUSY: only src grant_r may be yumi'd; other sources ignored even if valid. Each accepted word
//    cnt-=1; accept with cnt==1 -> IDLE, rr_ptr=grant_r+1 mod N. Grant source stalling (v=0) just
//    holds BUSY indefinitely (no timeout).
//  - Wrap: rr_ptr from N-1 wraps to 0; num_src_p=1 degenerates to packet pass-through.
//  - Simultaneous valids in IDLE: exactly one yumi; the losing source is first in line next packet.
//  - Reset mid-packet: state dropped immediately (next edge), any held output word discarded;
//    next accepted word from any source is treated as a header. Upstream must resync.
//  - grant_o = busy_o ? onehot(grant_r) : 0; busy_o registered state bit.
// CONFIGURATION
//  BSG_ZYNQ_PACKET_ARB_TAG_EN
//   defined: on header words only, data_o[data_width_p-1 -: safe_clog2(num_src_p)] is overwritten
//     with the source index; payload words and len field unmodified (requires len_width_p +
//     safe_clog2(num_src_p) <= data_width_p, asserted at elaboration).
//   undefined: all words pass unmodified; src_id_o remains the only source indication.
// TESTING
//  T1 reset, src0 header 0x0000_0000 -> data_o=0x0000_0000, v_o=1 one cycle later, stays IDLE.
//  T2 src0,src1 both stream len-0 headers, ready_i=1 -> src_id_o sequence 0,1,0,1; one yumi/cycle.
//  T3 src0 header len=3 + 3 payload, src1 valid throughout -> 4 contiguous src0 words, then src1;
//     busy_o=1 for exactly the 3 payload accept cycles.
//  T4 v_o=1, ready_i=0 for 5 cycles -> data_o stable, src_yumi_o=0; ready_i=1 -> no loss or duplicate.
//  T5 reset_i pulsed after 2 of 4 words of src0 packet (len=3) -> v_o=0, busy_o=0 next cycle; then
//     src1 len-0 header granted first-come, rr_ptr=0 honoured.
//  T6 TAG_EN, N=2: src1 header 0x0000_0002 -> data_o=0x8000_0002; payload 0xFFFF_FFFF unchanged.
//     TAG off: same header -> 0x0000_0002.

Source files
------------

// File: rtl/bsg_zynq_fifo_packet_arbiter.sv
// Round-robin packet arbiter: N valid/yumi sources share one registered ready/valid output; grant held for a whole packet.
// Optional BSG_ZYNQ_PACKET_ARB_TAG_EN stamps the source index into the top bits of header words.
module bsg_zynq_fifo_packet_arbiter #(
  parameter int num_src_p    = 2,
  parameter int data_width_p = 32,
  parameter int len_width_p  = 8,
  localparam int id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*data_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_yumi_o,
  output logic [data_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic [num_src_p-1:0]              grant_o,
  output logic                              busy_o,
  output logic [id_width_lp-1:0]            src_id_o
);

  typedef enum logic {e_idle, e_busy} state_e;

  localparam logic [id_width_lp-1:0] last_lp = id_width_lp'(num_src_p - 1);

  state_e                    r_state, w_state_n;
  logic [id_width_lp-1:0]    r_rr_ptr, w_rr_ptr_n, r_grant, w_grant_n, r_src_id;
  logic [id_width_lp-1:0]    w_sel, w_sel_inc;
  logic [len_width_p-1:0]    r_cnt, w_cnt_n;
  logic                      r_v;
  logic [data_width_p-1:0]   r_data, w_word_raw, w_word;
  logic                      w_take, w_found, w_sel_v, w_acc;

`ifdef BSG_ZYNQ_PACKET_ARB_TAG_EN
  if (len_width_p + id_width_lp > data_width_p) begin : g_bad_cfg
    $error("tag field overlaps header length field");
  end
`endif

  // In IDLE scan from rr_ptr for the first valid source; in BUSY only the locked source counts.
  always_comb begin
    w_take  = ~r_v | ready_i;
    w_sel   = '0;
    w_found = 1'b0;
    if (r_state == e_idle) begin
      for (int unsigned k = 0; k < num_src_p; k++) begin
        for (int unsigned i = 0; i < num_src_p; i++) begin
          if (!w_found && src_v_i[i] && (i == (32'(r_rr_ptr) + k) % num_src_p)) begin
            w_found = 1'b1;
            w_sel   = id_width_lp'(i);
          end
        end
      end
    end else begin
      w_sel = r_grant;
    end
    w_sel_v    = 1'b0;
    w_word_raw = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      if (id_width_lp'(i) == w_sel) begin
        w_sel_v    = src_v_i[i];
        w_word_raw = src_data_i[i*data_width_p +: data_width_p];
      end
    end
    w_acc = w_take & w_sel_v;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      src_yumi_o[i] = w_acc & (id_width_lp'(i) == w_sel);
    end
    w_sel_inc = (w_sel == last_lp) ? '0 : w_sel + 1'b1;
  end

  always_comb begin
    w_word = w_word_raw;
`ifdef BSG_ZYNQ_PACKET_ARB_TAG_EN
    if (r_state == e_idle) begin
      w_word[data_width_p-1 -: id_width_lp] = w_sel;
    end
`endif
  end

  always_comb begin
    w_state_n  = r_state;
    w_rr_ptr_n = r_rr_ptr;
    w_grant_n  = r_grant;
    w_cnt_n    = r_cnt;
    if (w_acc) begin
      case (r_state)
        e_idle: begin
          if (w_word_raw[len_width_p-1:0] == '0) begin
            w_rr_ptr_n = w_sel_inc;
          end else begin
            w_state_n = e_busy;
            w_grant_n = w_sel;
            w_cnt_n   = w_word_raw[len_width_p-1:0];
          end
        end
        e_busy: begin
          w_cnt_n = r_cnt - 1'b1;
          if (r_cnt == len_width_p'(1)) begin
            w_state_n  = e_idle;
            w_rr_ptr_n = w_sel_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= e_idle;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_v      <= 1'b0;
      r_data   <= '0;
      r_src_id <= '0;
    end else begin
      r_state  <= w_state_n;
      r_rr_ptr <= w_rr_ptr_n;
      r_grant  <= w_grant_n;
      r_cnt    <= w_cnt_n;
      if (w_acc) begin
        r_v      <= 1'b1;
        r_data   <= w_word;
        r_src_id <= w_sel;
      end else if (ready_i) begin
        r_v <= 1'b0;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      grant_o[i] = (r_state == e_busy) && (id_width_lp'(i) == r_grant);
    end
  end

  assign v_o      = r_v;
  assign data_o   = r_data;
  assign src_id_o = r_src_id;
  assign busy_o   = (r_state == e_busy);

endmodule

// File: tb/tb_bsg_zynq_fifo_packet_arbiter.sv
// Self-checking bench for bsg_zynq_fifo_packet_arbiter: directed scenarios plus randomized packet traffic vs a queue-based model.
module tb_bsg_zynq_fifo_packet_arbiter;
  localparam int NS = 2;
  localparam int W = 32;
  localparam int L = 8;
  localparam int IDW = 1;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [NS*W-1:0] src_data_i;
  logic [NS-1:0]   src_v_i;
  logic [NS-1:0]   src_yumi_o;
  logic [W-1:0]    data_o;
  logic            v_o;
  logic            ready_i;
  logic [NS-1:0]   grant_o;
  logic            busy_o;
  logic [IDW-1:0]  src_id_o;

  bsg_zynq_fifo_packet_arbiter #(.num_src_p(NS), .data_width_p(W), .len_width_p(L)) dut (
    .clk_i(clk), .reset_i(reset_i), .src_data_i(src_data_i), .src_v_i(src_v_i),
    .src_yumi_o(src_yumi_o), .data_o(data_o), .v_o(v_o), .ready_i(ready_i),
    .grant_o(grant_o), .busy_o(busy_o), .src_id_o(src_id_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // source queues and packet-level model state
  logic [W-1:0] q [NS][$];
  bit           m_busy;
  int           m_owner, m_left, m_ptr, m_id;
  bit           m_v;
  logic [W-1:0] m_data;
  logic [W-1:0] sink_log[$];
  int           id_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_id = 0; m_v = 0; m_data = '0;
    for (int s = 0; s < NS; s++) q[s].delete();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    src_v_i = '0;
    ready_i = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    chk("reset_v_o", v_o, 0);
    chk("reset_busy_o", busy_o, 0);
    chk("reset_grant_o", grant_o, 0);
    chk("reset_src_id_o", src_id_o, 0);
    chk("reset_data_o", data_o, 0);
  endtask

  task automatic push_pkt(input int s);
    logic [W-1:0] r;
    int len;
    len = ($urandom_range(7) == 0) ? $urandom_range(20, 4) : $urandom_range(3);
    r = $urandom;
    q[s].push_back({r[W-1:L], L'(len)});
    for (int i = 0; i < len; i++) q[s].push_back($urandom);
  endtask

  // One clock: check registered outputs, drive inputs, check yumi, advance model.
  task automatic cycle(input bit rdy, input int vprob);
    logic [NS-1:0] g, ey;
    logic [W-1:0]  word;
    bit            take, hdr;
    int            win;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    chk("v_o", v_o, m_v);
    if (m_v) begin
      chk("data_o", data_o, m_data);
      chk("src_id_o", src_id_o, m_id);
    end
    chk("busy_o", busy_o, m_busy);
    chk("grant_o", grant_o, g);
    ready_i = rdy;
    if (v_o && rdy) begin
      sink_log.push_back(data_o);
      id_log.push_back(int'(src_id_o));
    end
    for (int s = 0; s < NS; s++) begin
      src_v_i[s] = (q[s].size() > 0) && ($urandom_range(99) < vprob);
      src_data_i[s*W +: W] = (q[s].size() > 0) ? q[s][0] : $urandom;
    end
    #1;
    take = !m_v || rdy;
    win = -1;
    if (!m_busy) begin
      for (int k = 0; k < NS; k++)
        if (win < 0 && src_v_i[(m_ptr + k) % NS]) win = (m_ptr + k) % NS;
    end else if (src_v_i[m_owner]) begin
      win = m_owner;
    end
    if (!take) win = -1;
    ey = '0;
    if (win >= 0) ey[win] = 1'b1;
    chk("src_yumi_o", src_yumi_o, ey);
    @(posedge clk);
    if (win >= 0) begin
      word = q[win].pop_front();
      hdr = !m_busy;
      if (hdr) begin
        if (word[L-1:0] == 0) m_ptr = (win + 1) % NS;
        else begin
          m_busy = 1; m_owner = win; m_left = int'(word[L-1:0]);
        end
`ifdef BSG_ZYNQ_PACKET_ARB_TAG_EN
        word[W-1 -: IDW] = IDW'(win);
`endif
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_ptr = (m_owner + 1) % NS;
        end
      end
      m_v = 1; m_data = word; m_id = win;
    end else if (rdy) begin
      m_v = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    logic [W-1:0] exp_hdr;
    reset_i = 1'b1;
    src_v_i = '0;
    src_data_i = '0;
    ready_i = 1'b1;
    @(negedge clk);
    do_reset();

    // T1: single len-0 header from src0
    q[0].push_back(32'h0000_0000);
    cycle(1, 100);
    chk("t1_v_o", v_o, 1);
    chk("t1_data_o", data_o, 32'h0);
    chk("t1_busy_o", busy_o, 0);
    cycle(1, 100);
    chk("t1_v_o_clear", v_o, 0);

    // T2: alternating len-0 headers
    do_reset();
    sink_log.delete(); id_log.delete();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(32'h100 + i * 32'h1000);
      q[1].push_back(32'h200 + i * 32'h1000);
    end
    for (int i = 0; i < 12; i++) cycle(1, 100);
    chk("t2_count", id_log.size(), 8);
    chk("t2_id0", id_log[0], 0);
    chk("t2_id1", id_log[1], 1);
    chk("t2_id2", id_log[2], 0);
    chk("t2_id3", id_log[3], 1);

    // T3: len-3 packet not interleaved with a waiting src1
    do_reset();
    sink_log.delete(); id_log.delete();
    q[0] = '{32'h3, 32'hA, 32'hB, 32'hC};
    q[1].push_back(32'h0000_0700);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 100);
      if (busy_o) busy_cnt++;
    end
    chk("t3_busy_cycles", busy_cnt, 3);
    chk("t3_count", sink_log.size(), 5);
    chk("t3_word3", sink_log[3], 32'hC);
    chk("t3_id4", id_log[4], 1);

    // T4: output stall
    do_reset();
    sink_log.delete(); id_log.delete();
    q[0] = '{32'h1100, 32'h2200, 32'h3300};
    cycle(1, 100);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 100);
      chk("t4_hold", data_o, 32'h1100);
    end
    for (int i = 0; i < 4; i++) cycle(1, 100);
    chk("t4_count", sink_log.size(), 3);
    chk("t4_w0", sink_log[0], 32'h1100);
    chk("t4_w1", sink_log[1], 32'h2200);
    chk("t4_w2", sink_log[2], 32'h3300);

    // T5: reset mid-packet
    do_reset();
    q[0] = '{32'h3, 32'h1, 32'h2, 32'h4};
    cycle(1, 100);
    cycle(1, 100);
    chk("t5_busy_before", busy_o, 1);
    do_reset();
    q[1].push_back(32'h5500);
    cycle(1, 100);
    chk("t5_v_o", v_o, 1);
    chk("t5_data_o", data_o, 32'h5500);
    chk("t5_src_id", src_id_o, 1);
    chk("t5_busy_o", busy_o, 0);

    // T6: header tagging
    do_reset();
    q[1] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h1234_5678};
`ifdef BSG_ZYNQ_PACKET_ARB_TAG_EN
    exp_hdr = 32'h8000_0002;
`else
    exp_hdr = 32'h0000_0002;
`endif
    cycle(1, 100);
    chk("t6_header", data_o, exp_hdr);
    cycle(1, 100);
    chk("t6_payload", data_o, 32'hFFFF_FFFF);
    cycle(1, 100);
    chk("t6_payload2", data_o, 32'h1234_5678);
    cycle(1, 100);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++) if (q[s].size() < 4) push_pkt(s);
      cycle($urandom_range(3) != 0, 70);
    end
    for (int c = 0; c < 500 && (q[0].size() > 0 || q[1].size() > 0 || m_v); c++) cycle(1, 100);
    chk("drain_done", (q[0].size() == 0 && q[1].size() == 0 && !m_v), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
